// File: rtl/result_writeback.sv
// Result writeback stage: selects an instruction's result (ALU, load, PC+4 or
// immediate), waits for load data when needed, and presents one register-file
// write per instruction together with a matching forwarding path.
module result_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            ResultSrc,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic                  RegWrite,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  we3,
  output logic [ADDR_WIDTH-1:0] a3,
  output logic [DATA_WIDTH-1:0] wd3,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_e;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_q, rd_d;
  logic                    regwrite_q, regwrite_d;
  logic [1:0]              src_q, src_d;
  // data_q only changes when a result enters WRITE, so it doubles as wd3
  // and naturally holds its value between writes.
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  // a3 needs its own register: rd_q is overwritten when a load is accepted,
  // but a3 must keep showing the last written address until the load lands.
  logic [ADDR_WIDTH-1:0]   a3_q, a3_d;
  logic                    we3_q, we3_d;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    accept;

  assign in_ready = (state_q != S_WAIT_MEM);
  assign busy     = (state_q != S_IDLE);
  assign accept   = in_valid && in_ready;

  // Result source mux for non-load instructions; loads take mem_rdata later.
  always_comb begin
    sel_data = alu_result;
    case (ResultSrc)
      SRC_PC4: sel_data = pc_plus4;
      SRC_IMM: sel_data = imm;
      default: sel_data = alu_result;
    endcase
  end

  // Next-state and next-output computation for the writeback FSM.
  always_comb begin
    // NOTE: every _d is defaulted first so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    src_d      = src_q;
    data_d     = data_q;
    a3_d       = a3_q;
    we3_d      = 1'b0;
    case (state_q)
      S_WAIT_MEM: begin
        if (mem_rvalid && (src_q == SRC_MEM)) begin
          state_d = S_WRITE;
          data_d  = mem_rdata;
          a3_d    = rd_q;
          we3_d   = regwrite_q && (rd_q != '0);
        end
      end
      default: begin
        // IDLE and WRITE both accept; WRITE falls back to IDLE when idle.
        state_d = S_IDLE;
        if (accept) begin
          rd_d       = rd;
          regwrite_d = RegWrite;
          src_d      = ResultSrc;
          if (ResultSrc == SRC_MEM) begin
            state_d = S_WAIT_MEM;
          end else begin
            state_d = S_WRITE;
            data_d  = sel_data;
            a3_d    = rd;
            we3_d   = RegWrite && (rd != '0);
          end
        end
      end
    endcase
  end

  // State and captured-register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; reset clears all captured registers so an
    // abandoned instruction can never reappear on the write port.
    if (rst) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      src_q      <= SRC_ALU;
      data_q     <= '0;
      a3_q       <= '0;
      we3_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      src_q      <= src_d;
      data_q     <= data_d;
      a3_q       <= a3_d;
      we3_q      <= we3_d;
    end
  end

  assign we3       = we3_q;
  assign a3        = a3_q;
  assign wd3       = data_q;
  assign fwd_valid = we3_q;
  assign fwd_rd    = a3_q;
  assign fwd_data  = data_q;

endmodule

// File: tb/tb_result_writeback.sv
// Self-checking bench for result_writeback: directed scenarios plus a
// randomized run compared against a transaction-level model.
module tb_result_writeback;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ResultSrc;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  result_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ResultSrc  (ResultSrc),
    .alu_result (alu_result),
    .pc_plus4   (pc_plus4),
    .imm        (imm),
    .rd         (rd),
    .RegWrite   (RegWrite),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .we3        (we3),
    .a3         (a3),
    .wd3        (wd3),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {we3,a3,wd3,fwd_valid,fwd_rd,fwd_data,busy,in_ready}.
  logic [77:0] obs;
  assign obs = {we3, a3, wd3, fwd_valid, fwd_rd, fwd_data, busy, in_ready};

  function automatic logic [77:0] exp_vec(input logic we, input logic [4:0] a,
                                          input logic [31:0] d, input logic b,
                                          input logic r);
    return {we, a, d, we, a, d, b, r};
  endfunction

  // Transaction-level model: one outstanding load at most, one write event
  // per completed instruction, last written address/data remembered.
  logic        m_wait;      // a load is outstanding
  logic        m_in_write;  // an instruction completes this cycle
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [4:0]  m_rd;
  logic        m_rw;

  // Advance one clock: update the model from the inputs seen at the edge,
  // then return at the falling edge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_wait = 1'b0; m_in_write = 1'b0; m_we = 1'b0;
      m_a3 = '0; m_wd = '0; m_rd = '0; m_rw = 1'b0;
    end else begin
      m_in_write = 1'b0;
      m_we       = 1'b0;
      if (m_wait) begin
        if (mem_rvalid) begin
          m_wait = 1'b0; m_in_write = 1'b1;
          m_we = m_rw && (m_rd != 5'd0); m_a3 = m_rd; m_wd = mem_rdata;
        end
      end else if (in_valid) begin
        if (ResultSrc == 2'b01) begin
          m_wait = 1'b1; m_rd = rd; m_rw = RegWrite;
        end else begin
          m_in_write = 1'b1;
          m_we = RegWrite && (rd != 5'd0);
          m_a3 = rd;
          m_wd = (ResultSrc == 2'b00) ? alu_result :
                 (ResultSrc == 2'b10) ? pc_plus4 : imm;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [77:0] e;
    rst = 1'b1; in_valid = 1'b1; ResultSrc = 2'b00; rd = 5'd3; RegWrite = 1'b1;
    alu_result = 32'h5555_5555; mem_rvalid = 1'b0;
    tick();
    e = exp_vec(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_held: got %h expected %h", obs, e); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_alu();
    logic [77:0] e;
    in_valid = 1'b1; ResultSrc = 2'b00; alu_result = 32'h0000_0010;
    pc_plus4 = 32'h0000_0404; imm = 32'h0000_0777; rd = 5'd5; RegWrite = 1'b1;
    tick();
    in_valid = 1'b0;
    e = exp_vec(1'b1, 5'd5, 32'h10, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL alu_write: got %h expected %h", obs, e); end
    tick();
    e = exp_vec(1'b0, 5'd5, 32'h10, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL alu_hold: got %h expected %h", obs, e); end
  endtask

  task automatic test_load();
    logic [77:0] e;
    // mem_rvalid on the accept cycle must not complete the load.
    in_valid = 1'b1; ResultSrc = 2'b01; rd = 5'd7; RegWrite = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    in_valid = 1'b0; mem_rvalid = 1'b0;
    e = exp_vec(1'b0, 5'd5, 32'h10, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL load_wait1: got %h expected %h", obs, e); end
    // An offer while waiting is not accepted.
    in_valid = 1'b1; ResultSrc = 2'b00; rd = 5'd9; alu_result = 32'h0000_AAAA;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL load_wait2: got %h expected %h", obs, e); end
    tick();
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL load_wait3: got %h expected %h", obs, e); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    e = exp_vec(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL load_write: got %h expected %h", obs, e); end
    tick();
    e = exp_vec(1'b0, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL load_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [77:0] e;
    pc_plus4 = 32'h0000_0100; imm = 32'h0000_0200; alu_result = 32'h0000_0300;
    RegWrite = 1'b1; in_valid = 1'b1;
    ResultSrc = 2'b10; rd = 5'd1;
    tick();
    ResultSrc = 2'b11; rd = 5'd2;
    e = exp_vec(1'b1, 5'd1, 32'h100, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_pc4: got %h expected %h", obs, e); end
    tick();
    ResultSrc = 2'b00; rd = 5'd3;
    e = exp_vec(1'b1, 5'd2, 32'h200, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_imm: got %h expected %h", obs, e); end
    tick();
    in_valid = 1'b0;
    e = exp_vec(1'b1, 5'd3, 32'h300, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_alu: got %h expected %h", obs, e); end
    tick();
    e = exp_vec(1'b0, 5'd3, 32'h300, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL b2b_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_x0();
    logic [77:0] e;
    in_valid = 1'b1; ResultSrc = 2'b00; alu_result = 32'h0000_1234;
    rd = 5'd0; RegWrite = 1'b1;
    tick();
    in_valid = 1'b0;
    e = exp_vec(1'b0, 5'd0, 32'h1234, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL x0_write: got %h expected %h", obs, e); end
    tick();
    e = exp_vec(1'b0, 5'd0, 32'h1234, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL x0_idle: got %h expected %h", obs, e); end
  endtask

  task automatic test_reset_in_wait();
    logic [77:0] e;
    in_valid = 1'b1; ResultSrc = 2'b01; rd = 5'd4; RegWrite = 1'b1;
    tick();
    in_valid = 1'b0;
    e = exp_vec(1'b0, 5'd0, 32'h1234, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstwait_pending: got %h expected %h", obs, e); end
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_CAFE;
    e = exp_vec(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstwait_cleared: got %h expected %h", obs, e); end
    tick();
    mem_rvalid = 1'b0;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstwait_late_rvalid: got %h expected %h", obs, e); end
  endtask

  task automatic test_reset_priority();
    logic [77:0] e;
    in_valid = 1'b1; ResultSrc = 2'b11; imm = 32'h0BAD_F00D; rd = 5'd6; RegWrite = 1'b1;
    tick();
    e = exp_vec(1'b1, 5'd6, 32'h0BAD_F00D, 1'b1, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstprio_write: got %h expected %h", obs, e); end
    // Reset in WRITE together with a new accept: reset wins.
    rst = 1'b1; ResultSrc = 2'b00; alu_result = 32'h7777_0000; rd = 5'd8;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    e = exp_vec(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL rstprio_cleared: got %h expected %h", obs, e); end
  endtask

  task automatic test_random();
    logic [77:0] e;
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 49) == 0);
      in_valid   = ($urandom_range(0, 9) < 7);
      ResultSrc  = 2'($urandom_range(0, 3));
      alu_result = $urandom;
      pc_plus4   = $urandom;
      imm        = $urandom;
      mem_rdata  = $urandom;
      mem_rvalid = ($urandom_range(0, 9) < 4);
      rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      RegWrite   = ($urandom_range(0, 3) != 0);
      tick();
      e = exp_vec(m_we, m_a3, m_wd, m_wait || m_in_write, !m_wait);
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        bad++;
        if (bad <= 10) $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, e);
      end
    end
    rst = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; ResultSrc = 2'b00; alu_result = '0;
    pc_plus4 = '0; imm = '0; rd = '0; RegWrite = 1'b0; mem_rdata = '0;
    mem_rvalid = 1'b0;
    m_wait = 1'b0; m_in_write = 1'b0; m_we = 1'b0;
    m_a3 = '0; m_wd = '0; m_rd = '0; m_rw = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_x0();
    test_reset_in_wait();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
